// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DIV_WIDTH_DEF  = 16;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loads the period minus one, flags the last cycle of the bit.
module uart_bit_timer #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] load_val_i,
  input  logic                 en_i,
  output logic                 bit_end_c,
  output logic                 end_next_c
);

  logic [DIV_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DIV_WIDTH'(1);
    end
  end

  assign bit_end_c = en_i && (cnt_q == '0);

  // Lookahead: the counter will read zero in the next cycle.
  always_comb begin
    end_next_c = 1'b0;
    if (load_i) begin
      end_next_c = (load_val_i == '0);
    end else if (cnt_q == '0) begin
      end_next_c = 1'b1;
    end else begin
      end_next_c = en_i && (cnt_q == DIV_WIDTH'(1));
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops words from a show-ahead FIFO and serialises them onto tx_o.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DIV_WIDTH  = DIV_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_re_o,
  input  logic                  tx_en_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic                  stop_cnt_q;
  logic                  par_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  par_en_q;
  logic                  stop2_q;

  logic                  pop;
  logic                  bit_end;
  logic                  end_next;
  logic                  timer_load;
  logic [DIV_WIDTH-1:0]  timer_val;
  logic                  last_bit;
  logic                  stop_last;
  logic                  final_stop_next;
  logic                  done_d;

  // Pop only from IDLE; the following cycle is always START, so pops never abut.
  always_comb begin
    pop             = rst_ni && (state_q == IDLE) && tx_en_i && !fifo_empty_i;
    timer_load      = pop || bit_end;
    timer_val       = pop ? baud_div_i : div_q;
    last_bit        = (bit_cnt_q == LAST_BIT);
    stop_last       = !stop2_q || stop_cnt_q;
    final_stop_next = 1'b0;
    if ((state_q == STOP) && stop_last && !bit_end) begin
      final_stop_next = 1'b1;
    end else if (bit_end && (state_q == STOP) && stop2_q && !stop_cnt_q) begin
      final_stop_next = 1'b1;
    end else if (bit_end && !stop2_q &&
                 (((state_q == DATA) && last_bit && !par_en_q) || (state_q == PARITY))) begin
      final_stop_next = 1'b1;
    end
    done_d = final_stop_next && end_next;
  end

  assign fifo_re_o = pop;

  uart_bit_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_bit_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .en_i       (state_q != IDLE),
    .bit_end_c  (bit_end),
    .end_next_c (end_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= done_d;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q    <= START;
            shift_q    <= fifo_rdata_i;
            div_q      <= baud_div_i;
            par_en_q   <= parity_en_i;
            stop2_q    <= stop2_i;
            par_q      <= (parity_mode_e'(parity_odd_i) == PARITY_ODD);
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_o       <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            tx_o    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            par_q   <= par_q ^ shift_q[0];
            shift_q <= shift_q >> 1;
            if (last_bit) begin
              if (par_en_q) begin
                state_q <= PARITY;
                tx_o    <= par_q ^ shift_q[0];
              end else begin
                state_q <= STOP;
                tx_o    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
              tx_o      <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_o    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!stop_last) begin
              stop_cnt_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_o    <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

UART transmit engine that drains a show-ahead synchronous FIFO. It sits on the FIFO's read side: it pops one word at a time and serialises each word onto `tx_o` as an 8N1/8E1/8O1/8N2-style frame. The bit period is set at run time by a clocks-per-bit divisor. It is the consumer counterpart to the CPU-written TX FIFO in the UART peripheral.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 5..9.
- `DIV_WIDTH`, default 16: width of the bit-period divisor.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `fifo_rdata_i`  in  `DATA_WIDTH`  FIFO head word; valid whenever `fifo_empty_i`=0.
- `fifo_empty_i`  in  1  FIFO empty flag, registered inside the FIFO.
- `fifo_re_o`  out  1  pop strobe; one-cycle pulse.
- `tx_en_i`  in  1  permits new frames to start.
- `baud_div_i`  in  `DIV_WIDTH`  bit period in cycles, minus 1.
- `parity_en_i`  in  1  adds a parity bit.
- `parity_odd_i`  in  1  selects odd parity (1) or even parity (0).
- `stop2_i`  in  1  selects two stop bits (1) or one (0).
- `tx_o`  out  1  serial line, idle high.
- `busy_o`  out  1  high from the cycle after a pop through the last stop cycle.
- `done_o`  out  1  one-cycle pulse in the final cycle of the last stop bit.

## Operation
- FSM states:
  - IDLE: next state START.
  - START: next state DATA.
  - DATA: next state PARITY if parity is enabled, otherwise STOP.
  - PARITY: next state STOP.
  - STOP: next state IDLE.
- Pop rule: `fifo_re_o` = (state==IDLE) & `tx_en_i` & ~`fifo_empty_i`. It is combinational.
- In the pop cycle, the block latches into frame registers:
  - `fifo_rdata_i` into the shift register;
  - `baud_div_i`, `parity_en_i`, `parity_odd_i` and `stop2_i`.
- Latched values govern the whole frame. Input changes mid-frame have no effect.
- Bit period P = latched `baud_div_i` + 1 cycles, range 1..2^`DIV_WIDTH`.
- Bit timer loads `baud_div` at each bit start and counts down. A bit ends when the timer is 0.
- Bit order: start bit 0, then data LSB first, then optional parity bit, then 1 or 2 stop bits of 1.
- Parity bit = XOR of the data bits, XOR `parity_odd`.
- Data bit index counter counts 0..`DATA_WIDTH`-1. The shift register shifts right at each data-bit end.
- Stop counter counts 1 or 2 bits.
- `tx_o` is driven from a flop. It never glitches.
- `tx_en_i` falling mid-frame: the current frame completes, and no further pop occurs.
- `fifo_re_o` never asserts in consecutive cycles. This guarantees the FIFO's one-cycle-lagged `empty_o` is never misread after popping the last entry.
- Reset values: `tx_o`=1, `busy_o`=0, `done_o`=0, `fifo_re_o`=0, state=IDLE, all counters and the shift register 0.
- Reset mid-frame (asynchronous):
  - `tx_o` returns high immediately;
  - the in-flight word is discarded;
  - no pop occurs while `rst_ni`=0.

## Timing
- Cycle 0 = pop cycle. `tx_o` falls at cycle 1.
- Start bit covers cycles 1..P.
- Data bit k covers cycles 1+(k+1)P .. (k+2)P.
- Frame length F = P·(1 + `DATA_WIDTH` + parity + stops) cycles, occupying cycles 1..F.
- `done_o` = 1 in cycle F. `busy_o` falls after cycle F.
- Back-to-back frames: the IDLE cycle F+1 pops the next word, and the next start bit begins at F+2. This gives exactly one extra idle-high cycle between frames.
- Latency from `fifo_empty_i` falling (while IDLE and enabled) to `fifo_re_o` is 0 cycles. Latency to the start bit is 1 cycle.

## Structure
- Package `uart_pkg` contains:
  - the `tx_state_e` enum {IDLE, START, DATA, PARITY, STOP};
  - the default `DATA_WIDTH` and `DIV_WIDTH` constants;
  - the parity-mode constants.
- Sub-module `uart_bit_timer`:
  - inputs: load, load value, enable;
  - output: `bit_end` pulse;
  - down-counter of width `DIV_WIDTH`.
- The top level holds the FSM, shift register, bit and stop counters, parity accumulator and output flops.

## Test plan
- 0x55, `baud_div_i`=3, no parity, 1 stop:
  - `fifo_re_o` pulses once at cycle 0;
  - `tx_o` reads 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles over cycles 1..40;
  - `done_o` fires at cycle 40.
- 0x03, `baud_div_i`=1, parity enabled:
  - even parity: parity bit 0 at cycles 19..20;
  - odd parity: parity bit 1 at cycles 19..20;
  - `stop2_i`=1: `tx_o` stays high at cycles 21..24, and `done_o` fires at 24.
- FIFO holds 0xA5, 0x0F, `baud_div_i`=0:
  - pops occur at cycles 0 and 11;
  - second start bit at cycle 12;
  - `fifo_re_o` never asserts two cycles in a row;
  - after the last pop the FIFO's empty flag lags one cycle, and no spurious pop occurs.
- `fifo_empty_i`=1 or `tx_en_i`=0 for 100 cycles: `fifo_re_o`=0, `tx_o`=1, `busy_o`=0.
- Change `baud_div_i` from 3 to 7, and drop `tx_en_i`, at data bit 2: the frame keeps P=4 and finishes at cycle 40; no further pop occurs.
- Assert `rst_ni` at data bit 3:
  - `tx_o`=1 and `busy_o`=0 in the same cycle, asynchronously;
  - after release with the FIFO non-empty and `tx_en_i`=1, a pop occurs on the first clock.
